// File: rtl/systolic_seq_ctrl_if.sv
// Bus bundle between the ibus decoder / array datapath and the systolic run sequencer.
interface systolic_seq_ctrl_if #(
  parameter int ADR_W = 9
);
  logic             wen;
  logic [15:0]      ibus_wadr;
  logic [15:0]      ibus_wdata;
  logic             ren;
  logic [15:0]      ibus_radr;
  logic [15:0]      ctrl_rdata;
  logic             ctrl_hit;
  logic             abuf_ren;
  logic [ADR_W-1:0] abuf_radr;
  logic             pe_clr;
  logic             pe_en;
  logic             obuf_we;
  logic [ADR_W-1:0] obuf_wadr;
  logic             busy;
  logic             done;

  modport master (
    output wen, ibus_wadr, ibus_wdata, ren, ibus_radr,
    input  ctrl_rdata, ctrl_hit, abuf_ren, abuf_radr, pe_clr, pe_en,
           obuf_we, obuf_wadr, busy, done
  );

  modport slave (
    input  wen, ibus_wadr, ibus_wdata, ren, ibus_radr,
    output ctrl_rdata, ctrl_hit, abuf_ren, abuf_radr, pe_clr, pe_en,
           obuf_we, obuf_wadr, busy, done
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Systolic run sequencer: ibus control registers, A/B buffer address stepping, PE gating, obuf commit.
// Optional SYS_ABORT_EN: START write with wdata[1]=1 while busy aborts the sequence.
module systolic_seq_ctrl #(
  parameter int ADR_W     = 9,
  parameter int DRAIN_CYC = 3
) (
  input logic                clk,
  input logic                rst_n,
  systolic_seq_ctrl_if.slave bus
);

  localparam logic [15:0] ADR_START  = 16'hFFF0;
  localparam logic [15:0] ADR_MAX    = 16'hFFF1;
  localparam logic [15:0] ADR_RUN    = 16'hFFF2;
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE
  } state_t;

  state_t           r_state, w_state_n;
  logic [15:0]      r_max, r_run_max;
  logic [15:0]      r_feed_cnt, w_feed_cnt_n;
  logic [15:0]      r_drain_cnt, w_drain_cnt_n;
  logic [15:0]      r_run_cnt, w_run_cnt_n;
  logic [ADR_W-1:0] r_adr_cnt, w_adr_cnt_n;
  logic [ADR_W-1:0] r_abuf_radr, w_abuf_radr_n;
  logic [ADR_W-1:0] r_obuf_wadr, w_obuf_wadr_n;
  logic             r_abuf_ren, r_pe_clr, r_pe_en, r_obuf_we, r_busy, r_done;
  logic             w_done_n;
  logic [15:0]      r_ctrl_rdata;
  logic             r_ctrl_hit;
  logic             w_idle, w_start_wr, w_start, w_abort;

  assign w_idle     = (r_state == S_IDLE);
  assign w_start_wr = bus.wen && (bus.ibus_wadr == ADR_START);
  assign w_start    = w_start_wr && bus.ibus_wdata[0] && w_idle;
`ifdef SYS_ABORT_EN
  assign w_abort    = w_start_wr && bus.ibus_wdata[1] && !w_idle;
`else
  assign w_abort    = 1'b0;
`endif

  always_comb begin
    w_state_n     = r_state;
    w_feed_cnt_n  = r_feed_cnt;
    w_drain_cnt_n = r_drain_cnt;
    w_run_cnt_n   = r_run_cnt;
    w_adr_cnt_n   = r_adr_cnt;
    w_done_n      = 1'b0;
    w_abuf_radr_n = r_abuf_radr;
    w_obuf_wadr_n = r_obuf_wadr;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_n     = S_CLEAR;
          w_feed_cnt_n  = '0;
          w_drain_cnt_n = '0;
          w_run_cnt_n   = '0;
          w_adr_cnt_n   = '0;
        end
      end
      S_CLEAR: begin
        w_state_n    = S_FEED;
        w_feed_cnt_n = '0;
      end
      S_FEED: begin
        if (r_feed_cnt == r_max) begin
          w_state_n     = (DRAIN_CYC == 0) ? S_WRITE : S_DRAIN;
          w_drain_cnt_n = '0;
        end else begin
          w_feed_cnt_n = r_feed_cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_state_n = S_WRITE;
        else                           w_drain_cnt_n = r_drain_cnt + 16'd1;
      end
      S_WRITE: begin
        if (r_run_cnt == r_run_max) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_state_n   = S_CLEAR;
          w_run_cnt_n = r_run_cnt + 16'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Abort overrides everything above, including a WRITE about to be entered.
    if (w_abort) begin
      w_state_n = S_IDLE;
      w_done_n  = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state.
    if (w_state_n == S_FEED) begin
      w_abuf_radr_n = r_adr_cnt;
      w_adr_cnt_n   = r_adr_cnt + 1'b1;
    end
    if (w_state_n == S_WRITE) w_obuf_wadr_n = w_run_cnt_n[ADR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_feed_cnt  <= '0;
      r_drain_cnt <= '0;
      r_run_cnt   <= '0;
      r_adr_cnt   <= '0;
      r_abuf_radr <= '0;
      r_obuf_wadr <= '0;
      r_abuf_ren  <= 1'b0;
      r_pe_clr    <= 1'b0;
      r_pe_en     <= 1'b0;
      r_obuf_we   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_feed_cnt  <= w_feed_cnt_n;
      r_drain_cnt <= w_drain_cnt_n;
      r_run_cnt   <= w_run_cnt_n;
      r_adr_cnt   <= w_adr_cnt_n;
      r_abuf_radr <= w_abuf_radr_n;
      r_obuf_wadr <= w_obuf_wadr_n;
      r_abuf_ren  <= (w_state_n == S_FEED);
      r_pe_clr    <= (w_state_n == S_CLEAR);
      r_pe_en     <= (w_state_n == S_FEED) || (w_state_n == S_DRAIN);
      r_obuf_we   <= (w_state_n == S_WRITE);
      r_busy      <= (w_state_n != S_IDLE);
      r_done      <= w_done_n;
    end
  end

  // Config registers are frozen during a sequence; readback reflects pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max        <= '0;
      r_run_max    <= '0;
      r_ctrl_rdata <= '0;
      r_ctrl_hit   <= 1'b0;
    end else begin
      if (bus.wen && w_idle) begin
        if (bus.ibus_wadr == ADR_MAX) r_max     <= bus.ibus_wdata;
        if (bus.ibus_wadr == ADR_RUN) r_run_max <= bus.ibus_wdata;
      end
      r_ctrl_hit   <= 1'b0;
      r_ctrl_rdata <= '0;
      if (bus.ren) begin
        case (bus.ibus_radr)
          ADR_START: begin
            r_ctrl_hit   <= 1'b1;
            r_ctrl_rdata <= {15'b0, r_busy};
          end
          ADR_MAX: begin
            r_ctrl_hit   <= 1'b1;
            r_ctrl_rdata <= r_max;
          end
          ADR_RUN: begin
            r_ctrl_hit   <= 1'b1;
            r_ctrl_rdata <= r_run_max;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.abuf_ren   = r_abuf_ren;
  assign bus.abuf_radr  = r_abuf_radr;
  assign bus.pe_clr     = r_pe_clr;
  assign bus.pe_en      = r_pe_en;
  assign bus.obuf_we    = r_obuf_we;
  assign bus.obuf_wadr  = r_obuf_wadr;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ctrl_rdata = r_ctrl_rdata;
  assign bus.ctrl_hit   = r_ctrl_hit;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_systolic_seq_ctrl;
  localparam int ADR_W     = 9;
  localparam int DRAIN_CYC = 3;
  localparam int AMOD      = 1 << ADR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.ADR_W(ADR_W)) bus ();

  systolic_seq_ctrl #(.ADR_W(ADR_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int busy_c;
    int clr_c;
    int en_c;
  } seq_rec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          feed_q[$];
  int          obuf_q[$];
  seq_rec_t    done_q[$];
  logic [16:0] rd_q[$];

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: a sequence is a list of feed addresses, obuf writes and a cycle budget.
  task automatic push_seq(input int m, input int r);
    seq_rec_t rec;
    for (int rr = 0; rr <= r; rr++) begin
      for (int k = 0; k <= m; k++) feed_q.push_back((rr * (m + 1) + k) % AMOD);
      obuf_q.push_back(rr % AMOD);
    end
    rec.busy_c = (r + 1) * (2 + (m + 1) + DRAIN_CYC);
    rec.clr_c  = r + 1;
    rec.en_c   = (r + 1) * ((m + 1) + DRAIN_CYC);
    done_q.push_back(rec);
  endtask

  // Monitor
  logic rd_fire = 1'b0;
  int   bcnt = 0, ccnt = 0, ecnt = 0;
  always @(posedge clk) rd_fire <= bus.ren;

  always @(negedge clk) begin
    seq_rec_t    rec;
    logic [16:0] e;
    if (bus.abuf_ren) begin
      if (feed_q.size() == 0) chk("abuf_ren_unexpected", int'(bus.abuf_ren), 0);
      else                    chk("abuf_radr", int'(bus.abuf_radr), feed_q.pop_front());
    end
    if (bus.obuf_we) begin
      if (obuf_q.size() == 0) chk("obuf_we_unexpected", int'(bus.obuf_we), 0);
      else                    chk("obuf_wadr", int'(bus.obuf_wadr), obuf_q.pop_front());
    end
    if (rd_fire) begin
      if (rd_q.size() == 0) chk("read_unexpected", 1, int'(rd_q.size()));
      else begin
        e = rd_q.pop_front();
        chk("ctrl_hit", int'(bus.ctrl_hit), int'(e[16]));
        chk("ctrl_rdata", int'(bus.ctrl_rdata), int'(e[15:0]));
      end
    end else if (bus.ctrl_hit) begin
      chk("ctrl_hit_spurious", int'(bus.ctrl_hit), 0);
    end
    if (bus.busy) begin
      bcnt++;
      if (bus.pe_clr) ccnt++;
      if (bus.pe_en)  ecnt++;
      if (bus.done) chk("done_while_busy", int'(bus.done), 0);
    end else begin
      if (bus.done) begin
        if (done_q.size() == 0) chk("done_unexpected", int'(bus.done), 0);
        else begin
          rec = done_q.pop_front();
          chk("busy_cycles", bcnt, rec.busy_c);
          chk("pe_clr_cycles", ccnt, rec.clr_c);
          chk("pe_en_cycles", ecnt, rec.en_c);
        end
      end
      bcnt = 0; ccnt = 0; ecnt = 0;
    end
  end

  // Bus tasks: called at posedge+1, return at the next posedge+1.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.wen = 1'b1; bus.ibus_wadr = a; bus.ibus_wdata = d;
    @(posedge clk); #1;
    bus.wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic hit, input logic [15:0] d);
    rd_q.push_back({hit, d});
    bus.ren = 1'b1; bus.ibus_radr = a;
    @(posedge clk); #1;
    bus.ren = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (bus.busy && i < budget) begin @(posedge clk); #1; i++; end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},       int'(bus.busy), 0);
    chk({tag, "_done"},       int'(bus.done), 0);
    chk({tag, "_abuf_ren"},   int'(bus.abuf_ren), 0);
    chk({tag, "_abuf_radr"},  int'(bus.abuf_radr), 0);
    chk({tag, "_pe_clr"},     int'(bus.pe_clr), 0);
    chk({tag, "_pe_en"},      int'(bus.pe_en), 0);
    chk({tag, "_obuf_we"},    int'(bus.obuf_we), 0);
    chk({tag, "_obuf_wadr"},  int'(bus.obuf_wadr), 0);
    chk({tag, "_ctrl_hit"},   int'(bus.ctrl_hit), 0);
    chk({tag, "_ctrl_rdata"}, int'(bus.ctrl_rdata), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, r, k, i;
    bus.wen = 1'b0; bus.ibus_wadr = '0; bus.ibus_wdata = '0;
    bus.ren = 1'b0; bus.ibus_radr = '0;
    #12;
    check_zero("reset");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: MAX=3, RUN=3, with dropped writes and a status read while busy
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd3);
    push_seq(3, 3);
    wr(16'hFFF0, 16'h0001);
    chk("busy_after_start", int'(bus.busy), 1);
    chk("pe_clr_after_start", int'(bus.pe_clr), 1);
    wr(16'hFFF1, 16'd7);
    wr(16'hFFF0, 16'h0001);
    rd(16'hFFF0, 1'b1, 16'd1);
    wait_idle(100);
    rd(16'hFFF1, 1'b1, 16'd3);
    rd(16'hFFF2, 1'b1, 16'd3);

    // Minimal sequence
    wr(16'hFFF1, 16'd0);
    wr(16'hFFF2, 16'd0);
    push_seq(0, 0);
    wr(16'hFFF0, 16'h0001);
    wait_idle(20);

    // START with bit0 clear does nothing; invalid addresses miss
    wr(16'hFFF0, 16'hFFFE);
    rd(16'hFFF0, 1'b1, 16'd0);
    rd(16'h1234, 1'b0, 16'd0);
    rd(16'hFFF3, 1'b0, 16'd0);

    // Read of START in the same cycle as the start write sees the old busy
    push_seq(0, 0);
    rd_q.push_back({1'b1, 16'd0});
    bus.wen = 1'b1; bus.ibus_wadr = 16'hFFF0; bus.ibus_wdata = 16'h0001;
    bus.ren = 1'b1; bus.ibus_radr = 16'hFFF0;
    @(posedge clk); #1;
    bus.wen = 1'b0; bus.ren = 1'b0;
    wait_idle(20);

    // Randomized sequences
    for (int it = 0; it < 6; it++) begin
      m = int'($urandom_range(0, 5));
      r = int'($urandom_range(0, 3));
      wr(16'hFFF1, 16'(m));
      wr(16'hFFF2, 16'(r));
      rd(16'hFFF1, 1'b1, 16'(m));
      rd(16'hFFF2, 1'b1, 16'(r));
      push_seq(m, r);
      wr(16'hFFF0, 16'h0001);
      k = int'($urandom_range(0, 3));
      cycles(k);
      rd(16'hFFF0, 1'b1, 16'd1);
      wait_idle(200);
    end

    // Back-to-back: START accepted in the done cycle
    wr(16'hFFF1, 16'd1);
    wr(16'hFFF2, 16'd1);
    push_seq(1, 1);
    push_seq(1, 1);
    wr(16'hFFF0, 16'h0001);
    i = 0;
    while (!bus.done && i < 100) begin @(posedge clk); #1; i++; end
    chk("done_seen", int'(bus.done), 1);
    wr(16'hFFF0, 16'h0001);
    chk("busy_after_b2b_start", int'(bus.busy), 1);
    wait_idle(100);

    // START with bit1 during DRAIN of run 1
    wr(16'hFFF1, 16'd1);
    wr(16'hFFF2, 16'd2);
`ifdef SYS_ABORT_EN
    for (int a = 0; a < 4; a++) feed_q.push_back(a);
    obuf_q.push_back(0);
`else
    push_seq(1, 2);
`endif
    wr(16'hFFF0, 16'h0001);
    cycles(10);
    wr(16'hFFF0, 16'h0002);
`ifdef SYS_ABORT_EN
    chk("busy_after_abort", int'(bus.busy), 0);
    rd(16'hFFF0, 1'b1, 16'd0);
`else
    chk("busy_after_ignored_abort", int'(bus.busy), 1);
    rd(16'hFFF0, 1'b1, 16'd1);
`endif
    wait_idle(100);

    // Reset during the second FEED
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd2);
    push_seq(3, 2);
    wr(16'hFFF0, 16'h0001);
    cycles(11);
    chk("in_second_feed_radr", int'(bus.abuf_radr), 5);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    feed_q.delete();
    obuf_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(16'hFFF1, 1'b1, 16'd0);
    rd(16'hFFF2, 1'b1, 16'd0);
    cycles(3);

    // Address wrap with 601 single-feed runs
    wr(16'hFFF1, 16'd0);
    wr(16'hFFF2, 16'd600);
    rd(16'hFFF2, 1'b1, 16'd600);
    push_seq(0, 600);
    wr(16'hFFF0, 16'h0001);
    wait_idle(5000);

    cycles(4);
    chk("feed_q_left", feed_q.size(), 0);
    chk("obuf_q_left", obuf_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
